arbitro_memoria: RTL and testbench

- Sits between the pipeline's two memory clients (IF instruction fetch, MEM-stage data access) and the single-ported shared memory. Only one access may be outstanding at a time.
- Serialises both clients onto one memory port using a registered request/ready handshake.
- Gives data accesses priority over instruction fetches.
- Produces the pipeline-wide stall, and aborts any access that exceeds a bounded wait (timeout).

---
 rtl/arbitro_memoria.sv | 165 ++++++++++++++++
 tb/tb_arbitro_memoria.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
`default_nettype none
// arbitro_memoria: serialises instruction-fetch and data accesses onto one
// single-ported memory. Data has priority. The unit drives the pipeline stall and aborts any access that waits too long.
module arbitro_memoria #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   // instruction-fetch client
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_done,
   // data client
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_done,
   // pipeline control
   output logic              cpu_stall,
   // shared memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              bus_error
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA_WAIT = 2'd1,
      INST_WAIT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;

   logic accept_data;
   logic accept_inst;
   logic finish;
   logic abort;
   logic waiting;

   assign waiting = (state == DATA_WAIT) || (state == INST_WAIT);

   // Stall drops in the done cycle so the pipeline advances once per access.
   assign cpu_stall = (inst_req & ~inst_done) | (data_req & ~data_done);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept_data = 1'b0;
      accept_inst = 1'b0;
      finish      = 1'b0;
      abort       = 1'b0;
      case (state)
         IDLE: begin
            // A request whose done pulse is still high is the one just
            // served; masking it prevents a duplicate access.
            if (data_req && !data_done) begin
               state_nxt   = DATA_WAIT;
               accept_data = 1'b1;
            end else if (inst_req && !inst_done) begin
               state_nxt   = INST_WAIT;
               accept_inst = 1'b1;
            end
         end
         DATA_WAIT, INST_WAIT: begin
            if (mem_ready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Memory request channel: address, data and direction are frozen while
   // mem_req is high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (accept_data) begin
         mem_req   <= 1'b1;
         mem_we    <= data_we;
         mem_addr  <= data_addr;
         mem_wdata <= data_wdata;
      end else if (accept_inst) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= inst_addr;
      end else if (finish || abort) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (accept_data || accept_inst) begin
         wait_cnt <= '0;
      end else if (waiting && !mem_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inst_done  <= 1'b0;
         data_done  <= 1'b0;
         inst_rdata <= '0;
         data_rdata <= '0;
         bus_error  <= 1'b0;
      end else begin
         inst_done <= (finish || abort) && (state == INST_WAIT);
         data_done <= (finish || abort) && (state == DATA_WAIT);
         if (state == INST_WAIT) begin
            if (abort) begin
               inst_rdata <= '0;
            end else if (finish) begin
               inst_rdata <= mem_rdata;
            end
         end
         // Stores leave the load result register untouched.
         if (state == DATA_WAIT) begin
            if (abort) begin
               data_rdata <= '0;
            end else if (finish && !mem_we) begin
               data_rdata <= mem_rdata;
            end
         end
         if (abort) begin
            bus_error <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// Bench for arbitro_memoria: per-cycle vector table plus hand sequences for
// timeout and asynchronous reset.
module tb_arbitro_memoria;

   logic        clock = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_done;
   logic        data_req;
   logic        data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bus_error;

   int checks = 0;
   int errors = 0;

   arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_done  (inst_done),
      .data_req   (data_req),
      .data_we    (data_we),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_done  (data_done),
      .cpu_stall  (cpu_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .bus_error  (bus_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        rdy;
      logic [31:0] mrdata;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic        e_idone;
      logic        e_ddone;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
      logic        e_stall;
      logic        e_berr;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic rdy,
                        input logic [31:0] mrd);
      inst_req   = ir;
      inst_addr  = ia;
      data_req   = dr;
      data_we    = dw;
      data_addr  = da;
      data_wdata = dd;
      mem_ready  = rdy;
      mem_rdata  = mrd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ireq iaddr dreq dwe daddr dwdata rdy mrdata | mreq mwe maddr mwdata idone ddone irdata drdata stall berr
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      // single fetch, memory ready at once
      vecs[1]  = '{1, 32'h40, 0, 0, 0, 0, 1, 32'h8C220004,        1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0};
      vecs[2]  = '{1, 32'h40, 0, 0, 0, 0, 1, 32'h8C220004,        0, 0, 0, 0, 1, 0, 32'h8C220004, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 1, 32'h8C220004,             0, 0, 0, 0, 0, 0, 32'h8C220004, 0, 0, 0};
      // store with two wait cycles
      vecs[4]  = '{0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0,       1, 1, 32'h200, 32'hDEADBEEF, 0, 0, 32'h8C220004, 0, 1, 0};
      vecs[5]  = vecs[4];
      vecs[6]  = vecs[4];
      vecs[7]  = '{0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 32'h8C220004, 0, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 32'h8C220004, 0, 0, 0};
      // load where the client keeps data_req high through done
      vecs[9]  = '{0, 0, 1, 0, 32'h300, 0, 1, 32'hA5A5A5A5,       1, 0, 32'h300, 0, 0, 0, 32'h8C220004, 0, 1, 0};
      vecs[10] = '{0, 0, 1, 0, 32'h300, 0, 1, 32'hA5A5A5A5,       0, 0, 0, 0, 0, 1, 32'h8C220004, 32'hA5A5A5A5, 0, 0};
      vecs[11] = '{0, 0, 1, 0, 32'h300, 0, 1, 32'hA5A5A5A5,       0, 0, 0, 0, 0, 0, 32'h8C220004, 32'hA5A5A5A5, 1, 0};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 32'h8C220004, 32'hA5A5A5A5, 0, 0};
      // simultaneous requests, data wins, three wait cycles
      vecs[13] = '{1, 32'h44, 1, 0, 32'h100, 0, 0, 0,             1, 0, 32'h100, 0, 0, 0, 32'h8C220004, 32'hA5A5A5A5, 1, 0};
      vecs[14] = vecs[13];
      vecs[15] = vecs[13];
      vecs[16] = vecs[13];
      vecs[17] = '{1, 32'h44, 1, 0, 32'h100, 0, 1, 32'h11112222,  0, 0, 0, 0, 0, 1, 32'h8C220004, 32'h11112222, 1, 0};
      vecs[18] = '{1, 32'h44, 0, 0, 0, 0, 0, 0,                   1, 0, 32'h44, 0, 0, 0, 32'h8C220004, 32'h11112222, 1, 0};
      vecs[19] = '{1, 32'h44, 0, 0, 0, 0, 1, 32'h33334444,        0, 0, 0, 0, 1, 0, 32'h33334444, 32'h11112222, 0, 0};
      vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 32'h33334444, 32'h11112222, 0, 0};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr,
               vecs[i].dwdata, vecs[i].rdy, vecs[i].mrdata);
         step();
         chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_mreq));
         chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
         if (vecs[i].e_mreq)
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
         if (vecs[i].e_mreq && vecs[i].e_mwe)
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
         chk($sformatf("v%0d inst_done", i), 32'(inst_done), 32'(vecs[i].e_idone));
         chk($sformatf("v%0d data_done", i), 32'(data_done), 32'(vecs[i].e_ddone));
         chk($sformatf("v%0d inst_rdata", i), inst_rdata, vecs[i].e_irdata);
         chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].e_drdata);
         chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d bus_error", i), 32'(bus_error), 32'(vecs[i].e_berr));
      end

      // Timeout: memory never answers, abort after four wait cycles.
      drive(0, 0, 1, 0, 32'h500, 0, 0, 32'hFFFFFFFF);
      step();
      chk("to accept mem_req", 32'(mem_req), 1);
      chk("to accept mem_addr", mem_addr, 32'h500);
      for (int w = 1; w <= 3; w++) begin
         step();
         chk($sformatf("to wait%0d mem_req", w), 32'(mem_req), 1);
         chk($sformatf("to wait%0d data_done", w), 32'(data_done), 0);
         chk($sformatf("to wait%0d bus_error", w), 32'(bus_error), 0);
      end
      step();
      chk("to abort data_done", 32'(data_done), 1);
      chk("to abort data_rdata", data_rdata, 32'h0);
      chk("to abort bus_error", 32'(bus_error), 1);
      chk("to abort mem_req", 32'(mem_req), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("to after data_done", 32'(data_done), 0);
      chk("to after bus_error", 32'(bus_error), 1);
      drive(1, 32'h48, 0, 0, 0, 0, 1, 32'h00000013);
      step();
      chk("to fetch mem_req", 32'(mem_req), 1);
      step();
      chk("to fetch inst_done", 32'(inst_done), 1);
      chk("to fetch inst_rdata", inst_rdata, 32'h00000013);
      chk("to fetch bus_error sticky", 32'(bus_error), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Asynchronous reset in the middle of a data access.
      drive(0, 0, 1, 0, 32'h600, 0, 0, 32'h77777777);
      step();
      chk("rst pre mem_req", 32'(mem_req), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst async mem_req", 32'(mem_req), 0);
      chk("rst async bus_error", 32'(bus_error), 0);
      chk("rst async inst_rdata", inst_rdata, 32'h0);
      #2;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1, 32'h77777777);
      step();
      chk("rst late ready data_done", 32'(data_done), 0);
      chk("rst late ready mem_req", 32'(mem_req), 0);
      step();
      chk("rst late ready2 data_done", 32'(data_done), 0);
      chk("rst late ready2 data_rdata", data_rdata, 32'h0);
      drive(1, 32'h4C, 0, 0, 0, 0, 1, 32'hCAFEF00D);
      step();
      chk("rst next mem_req", 32'(mem_req), 1);
      chk("rst next mem_addr", mem_addr, 32'h4C);
      step();
      chk("rst next inst_done", 32'(inst_done), 1);
      chk("rst next inst_rdata", inst_rdata, 32'hCAFEF00D);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("rst next idle inst_done", 32'(inst_done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
